vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-002 SHALL have parameter H_SYNC, default 96, HS low width in clocks.
REQ-003 SHALL have parameter H_ACT, default 640, blank_n-high clocks per active line.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have parameter V_SYNC, default 2, VS low width in lines.
REQ-006 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-007 SHALL have port i_clk_25M  input  1  pixel clock; the only clock; all logic on posedge.
REQ-008 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port i_hs  input  1  horizontal sync, active-low.
REQ-010 SHALL have port i_vs  input  1  vertical sync, active-low.
REQ-011 SHALL have port i_blank_n  input  1  high during active pixels.
REQ-012 SHALL have port i_rgb  input  24  pixel data, sampled with i_blank_n.
REQ-013 SHALL have port o_locked  output  1  high in LOCKED state.
REQ-014 SHALL have port o_show_en  output  1  valid active pixel on o_rgb/coords.
REQ-015 SHALL have port o_x_cord  output  10  active line index, 0..V_ACT-1 (vertical).
REQ-016 SHALL have port o_y_cord  output  10  active pixel index in line, 0..H_ACT-1 (horizontal).
REQ-017 SHALL have port o_rgb  output  24  pixel data aligned to o_show_en.
REQ-018 SHALL have port o_frame_start  output  1  one-clock pulse, first active pixel of a locked frame.
REQ-019 SHALL have port o_err  output  1  one-clock pulse on any timing check failure.
REQ-020 SHALL have port o_err_cnt  output  8  count of o_err pulses, saturating at 255.

Function
REQ-021 SHALL register i_hs/i_vs/i_blank_n/i_rgb once (stage 1); all edge detection uses stage-1 values vs their previous-cycle copies.
REQ-022 SHALL run h_cnt: set to 0 on stage-1 HS falling edge, else +1, saturating at 1023.
REQ-023 SHALL, on each HS fall with a prior HS fall seen since entering MEASURE, check h_cnt+1 == H_TOTAL.
REQ-024 SHALL, on each HS rising edge, check HS low width == H_SYNC clocks.
REQ-025 SHALL count blank_n-high clocks per line; at each HS fall count SHALL be 0 or H_ACT, else fail.
REQ-026 SHALL run v_cnt: 0 on VS fall, +1 on each HS fall; on next VS fall check v_cnt == V_TOTAL.
REQ-027 SHALL check VS low width == V_SYNC lines (HS falls counted while VS low) at VS rise.
REQ-028 SHALL count lines with nonzero active pixels per frame; at VS fall count SHALL equal V_ACT.
REQ-029 SHALL implement FSM SEARCH (reset), MEASURE, LOCKED.
REQ-030 SEARCH -> MEASURE on VS fall; checks disabled in SEARCH.
REQ-031 MEASURE -> LOCKED on next VS fall if no check failed during the frame; any failure -> SEARCH.
REQ-032 LOCKED: checks continue; any failure -> SEARCH.
REQ-033 Every check failure in MEASURE or LOCKED SHALL pulse o_err one clock (multiple same-cycle failures = one pulse) and increment o_err_cnt.
REQ-034 o_y_cord SHALL be 0 at first blank_n-high clock of a line, +1 per blank_n-high clock; o_x_cord = index of active line since last VS fall.
REQ-035 o_show_en SHALL be 1 only when LOCKED and stage-1 blank_n high; latency 2 clocks from input pins to o_show_en/o_rgb/coords.
REQ-036 o_x_cord/o_y_cord/o_rgb SHALL be 0 when o_show_en is 0.
REQ-037 o_frame_start SHALL assert with o_show_en at x=0,y=0 only while LOCKED.
REQ-038 HS fall and VS fall in same cycle: VS processing first (v_cnt=0), then HS fall counted as line 0 start; no spurious failure.
REQ-039 Failure on the cycle that would enter LOCKED: failure wins, go to SEARCH.
REQ-040 Coordinates beyond H_ACT-1 / V_ACT-1 SHALL not wrap; failure is flagged at line/frame end per REQ-025/028.

Reset
REQ-041 While i_rst high at a clock edge: state SEARCH, all counters 0, pipeline regs 0, o_err_cnt 0, all outputs 0 on the next cycle.
REQ-042 Reset mid-frame SHALL discard partial measurements; relock needs a full frame after the next VS fall.

Verification
REQ-043 Ideal 800x525 stream from reset -> o_locked rises at 2nd VS fall; next frame 307200 o_show_en clocks, one o_frame_start.
REQ-044 Locked, one line of 801 clocks -> single o_err pulse, o_err_cnt=1, o_locked falls, relock after two VS falls.
REQ-045 Locked, HS low 95 clocks -> o_err pulse at HS rise, state SEARCH.
REQ-046 Pixel at blank_n line 45 col 0 with rgb=24'hABCDEF -> 2 clocks later o_x_cord=0, o_y_cord=0, o_rgb=24'hABCDEF; last pixel gives 479/639.
REQ-047 Force 300 failures -> o_err_cnt holds 255.
REQ-048 i_rst asserted mid-line while locked -> next cycle o_locked=0, o_show_en=0, o_err_cnt=0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: registers an incoming VGA sync/blank/RGB stream, measures
// its timing against the configured geometry, locks once a full frame matches,
// and emits per-pixel coordinates and data while locked.
//
// Handshake: none. The stream is free-running at one pixel per clock. o_show_en
// qualifies o_x_cord/o_y_cord/o_rgb/o_frame_start in the same cycle, and those
// outputs are held at zero whenever o_show_en is low.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_ACT   = 480
) (
  input  logic        i_clk_25M,
  input  logic        i_rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_blank_n,
  input  logic [23:0] i_rgb,
  output logic        o_locked,
  output logic        o_show_en,
  output logic [9:0]  o_x_cord,
  output logic [9:0]  o_y_cord,
  output logic [23:0] o_rgb,
  output logic        o_frame_start,
  output logic        o_err,
  output logic [7:0]  o_err_cnt,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      state;

  logic        s1_hs, s1_vs, s1_blank;
  logic [23:0] s1_rgb;
  logic        hs_d, vs_d;

  logic [9:0]  h_cnt, v_cnt, act_cnt, act_lines;
  logic        hs_armed;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        line_had_act;
  logic [10:0] lines_sum;
  logic [9:0]  lines_done, x_cur, y_cur, act_nxt, h_nxt, v_nxt;
  logic        fail_h_period, fail_h_sync, fail_h_act;
  logic        fail_v_total, fail_v_sync, fail_v_act;
  logic        err_any, show;

  assign o_dbg_state = state;

  // Stage-1 input registers plus the previous-cycle copies used for edge detection.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b0;
      s1_rgb   <= '0;
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
    end else begin
      s1_hs    <= i_hs;
      s1_vs    <= i_vs;
      s1_blank <= i_blank_n;
      s1_rgb   <= i_rgb;
      hs_d     <= s1_hs;
      vs_d     <= s1_vs;
    end
  end

  // Edge decode, next counter values, coordinates of the stage-1 pixel and timing checks.
  always_comb begin
    hs_fall = hs_d & ~s1_hs;
    hs_rise = ~hs_d & s1_hs;
    vs_fall = vs_d & ~s1_vs;
    vs_rise = ~vs_d & s1_vs;

    // A line ending at this HS fall counts as active if it carried any blank_n-high clock.
    line_had_act = (act_cnt != 10'd0);
    lines_sum    = {1'b0, act_lines} + {10'd0, line_had_act};
    lines_done   = lines_sum[10] ? 10'h3FF : lines_sum[9:0];

    x_cur = act_lines;
    if (vs_fall)      x_cur = 10'd0;
    else if (hs_fall) x_cur = lines_done;
    y_cur = hs_fall ? 10'd0 : act_cnt;

    act_nxt = y_cur;
    if (s1_blank && (y_cur != 10'h3FF)) act_nxt = y_cur + 10'd1;

    h_nxt = h_cnt;
    if (hs_fall)                h_nxt = 10'd0;
    else if (h_cnt != 10'h3FF)  h_nxt = h_cnt + 10'd1;

    // VS fall restarts the line count; a coincident HS fall is line 0 of the new frame.
    v_nxt = v_cnt;
    if (vs_fall)                          v_nxt = hs_fall ? 10'd1 : 10'd0;
    else if (hs_fall && v_cnt != 10'h3FF) v_nxt = v_cnt + 10'd1;

    fail_h_period = hs_fall && hs_armed && ((32'(h_cnt) + 32'd1) != H_TOTAL);
    fail_h_sync   = hs_rise && hs_armed && ((32'(h_cnt) + 32'd1) != H_SYNC);
    fail_h_act    = hs_fall && hs_armed && line_had_act && (32'(act_cnt) != H_ACT);
    fail_v_total  = vs_fall && (32'(v_cnt) != V_TOTAL);
    fail_v_sync   = vs_rise && (32'(v_cnt) != V_SYNC);
    fail_v_act    = vs_fall && (32'(lines_sum) != V_ACT);

    err_any = (state != ST_SEARCH) &&
              (fail_h_period || fail_h_sync || fail_h_act ||
               fail_v_total  || fail_v_sync || fail_v_act);

    show = (state == ST_LOCKED) && s1_blank;
  end

  // Free-running timing counters; hs_armed marks that a full line has started since measuring began.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      act_cnt   <= '0;
      act_lines <= '0;
      hs_armed  <= 1'b0;
    end else begin
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      act_cnt   <= act_nxt;
      act_lines <= x_cur;
      if (state == ST_SEARCH) hs_armed <= vs_fall & hs_fall;
      else if (hs_fall)       hs_armed <= 1'b1;
    end
  end

  // Lock FSM: a failure always wins over the transition into LOCKED.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      state    <= ST_SEARCH;
      o_locked <= 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (vs_fall) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (err_any) begin
            state <= ST_SEARCH;
          end else if (vs_fall) begin
            state    <= ST_LOCKED;
            o_locked <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (err_any) begin
            state    <= ST_SEARCH;
            o_locked <= 1'b0;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: pixel data and coordinates gated by show, error pulse and saturating count.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      o_show_en     <= 1'b0;
      o_x_cord      <= '0;
      o_y_cord      <= '0;
      o_rgb         <= '0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      o_err_cnt     <= '0;
    end else begin
      o_show_en     <= show;
      o_x_cord      <= show ? x_cur : 10'd0;
      o_y_cord      <= show ? y_cur : 10'd0;
      o_rgb         <= show ? s1_rgb : 24'd0;
      o_frame_start <= show && (x_cur == 10'd0) && (y_cur == 10'd0);
      o_err         <= err_any;
      if (err_any && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 40x20 raster so that
// several whole frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HSW = 4;
  localparam int HA0 = 8;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VSW = 2;
  localparam int VA0 = 5;
  localparam int VA  = 12;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_hs = 1'b1;
  logic        i_vs = 1'b1;
  logic        i_blank_n = 1'b0;
  logic [23:0] i_rgb = '0;
  logic        o_locked, o_show_en, o_frame_start, o_err;
  logic [9:0]  o_x_cord, o_y_cord;
  logic [23:0] o_rgb;
  logic [7:0]  o_err_cnt;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  // Per-stretch statistics gathered on every clock.
  int show_cnt = 0;
  int fs_cnt = 0;
  int err_pulses = 0;
  int pix_err = 0;
  int err_v = -1;
  int err_h = -1;

  // Expected outputs for the pixel driven one call earlier.
  bit          model_on = 1'b0;
  bit          model_locked = 1'b0;
  logic        exp_show = 1'b0;
  logic        exp_fs = 1'b0;
  logic [9:0]  exp_x = '0;
  logic [9:0]  exp_y = '0;
  logic [23:0] exp_rgb = '0;
  int          exp_v = -1;
  int          exp_h = -1;

  logic [9:0]  cap_fx, cap_fy, cap_lx, cap_ly;
  logic [23:0] cap_frgb, cap_lrgb;
  logic        cap_ffs;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_ACT(VA)
  ) dut (
    .i_clk_25M    (clk),
    .i_rst        (i_rst),
    .i_hs         (i_hs),
    .i_vs         (i_vs),
    .i_blank_n    (i_blank_n),
    .i_rgb        (i_rgb),
    .o_locked     (o_locked),
    .o_show_en    (o_show_en),
    .o_x_cord     (o_x_cord),
    .o_y_cord     (o_y_cord),
    .o_rgb        (o_rgb),
    .o_frame_start(o_frame_start),
    .o_err        (o_err),
    .o_err_cnt    (o_err_cnt),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock
  always #20 clk = ~clk;

  task automatic clear_stats();
    show_cnt = 0; fs_cnt = 0; err_pulses = 0; pix_err = 0; err_v = -1; err_h = -1;
  endtask

  // One clock: sample outputs (they belong to the previously driven pixel) and update stats.
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_show_en === 1'b1) show_cnt++;
    if (o_frame_start === 1'b1) fs_cnt++;
    if (o_err === 1'b1) begin
      err_pulses++;
      err_v = exp_v;
      err_h = exp_h;
    end
    if (model_on) begin
      if (o_show_en !== exp_show || o_x_cord !== exp_x || o_y_cord !== exp_y ||
          o_rgb !== exp_rgb || o_frame_start !== exp_fs) pix_err++;
    end
    if (exp_v == VA0 && exp_h == HA0) begin
      cap_fx = o_x_cord; cap_fy = o_y_cord; cap_frgb = o_rgb; cap_ffs = o_frame_start;
    end
    if (exp_v == VA0 + VA - 1 && exp_h == HA0 + HA - 1) begin
      cap_lx = o_x_cord; cap_ly = o_y_cord; cap_lrgb = o_rgb;
    end
  endtask

  // Drive one pixel and advance a clock; pv/ph are raster position (-1 when idle).
  task automatic drive(input logic hs, input logic vs, input logic blank,
                       input logic [23:0] rgb, input int pv, input int ph);
    logic n_show;
    i_hs = hs; i_vs = vs; i_blank_n = blank; i_rgb = rgb;
    n_show = model_locked && blank;
    tick();
    exp_show = n_show;
    exp_x    = n_show ? 10'(pv - VA0) : 10'd0;
    exp_y    = n_show ? 10'(ph - HA0) : 10'd0;
    exp_rgb  = n_show ? rgb : 24'd0;
    exp_fs   = n_show && (pv == VA0) && (ph == HA0);
    exp_v    = pv;
    exp_h    = ph;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 24'd0, -1, -1);
  endtask

  task automatic drive_line(input int v, input int len, input int hsw);
    logic        blank;
    logic [23:0] rgb;
    logic [7:0]  vb, hb;
    for (int h = 0; h < len; h++) begin
      blank = (v >= VA0) && (v < VA0 + VA) && (h >= HA0) && (h < HA0 + HA);
      vb = v[7:0];
      hb = h[7:0];
      rgb = (v == VA0 && h == HA0) ? 24'hABCDEF : {vb, hb, 8'hA5};
      drive(h >= hsw, v >= VSW, blank, rgb, v, h);
    end
  endtask

  task automatic drive_frame(input int bad_v, input int bad_len, input int bad_hsw);
    for (int v = 0; v < VT; v++)
      drive_line(v, (v == bad_v) ? bad_len : HT, (v == bad_v) ? bad_hsw : HSW);
  endtask

  task automatic test_reset();
    model_on = 1'b0; model_locked = 1'b0;
    i_rst = 1'b1;
    idle(3);
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b expected 0", o_locked); end
    checks++; if (o_show_en !== 1'b0) begin errors++; $display("FAIL rst_show: got %0b expected 0", o_show_en); end
    checks++; if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", o_err_cnt); end
    checks++; if (o_err !== 1'b0 || o_frame_start !== 1'b0) begin errors++; $display("FAIL rst_pulses: got err=%0b fs=%0b expected 0/0", o_err, o_frame_start); end
    checks++; if (o_x_cord !== 10'd0 || o_y_cord !== 10'd0 || o_rgb !== 24'd0) begin errors++; $display("FAIL rst_data: got x=%0d y=%0d rgb=%h expected 0", o_x_cord, o_y_cord, o_rgb); end
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", o_dbg_state); end
    i_rst = 1'b0;
    idle(4);
  endtask

  task automatic test_lock_acquire();
    // First frame measures; lock is taken at the VS fall that starts the second.
    clear_stats();
    model_on = 1'b1; model_locked = 1'b0;
    drive_frame(-1, HT, HSW);
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL measure_locked: got %0b expected 0", o_locked); end
    checks++; if (o_dbg_state !== 2'd1) begin errors++; $display("FAIL measure_state: got %0d expected 1", o_dbg_state); end
    checks++; if (pix_err != 0) begin errors++; $display("FAIL measure_pixels: got %0d bad cycles expected 0", pix_err); end
    clear_stats();
    model_locked = 1'b1;
    drive_frame(-1, HT, HSW);
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %0b expected 1", o_locked); end
    checks++; if (show_cnt != HA * VA) begin errors++; $display("FAIL lock_show_cnt: got %0d expected %0d", show_cnt, HA * VA); end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL lock_frame_start: got %0d expected 1", fs_cnt); end
    checks++; if (pix_err != 0) begin errors++; $display("FAIL lock_pixels: got %0d bad cycles expected 0", pix_err); end
    checks++; if (err_pulses != 0 || o_err_cnt !== 8'd0) begin errors++; $display("FAIL lock_no_err: got pulses=%0d cnt=%0d expected 0/0", err_pulses, o_err_cnt); end
  endtask

  task automatic test_pixel_coords();
    clear_stats();
    model_on = 1'b1; model_locked = 1'b1;
    drive_frame(-1, HT, HSW);
    checks++; if (cap_fx !== 10'd0 || cap_fy !== 10'd0) begin errors++; $display("FAIL first_coord: got x=%0d y=%0d expected 0/0", cap_fx, cap_fy); end
    checks++; if (cap_frgb !== 24'hABCDEF) begin errors++; $display("FAIL first_rgb: got %h expected abcdef", cap_frgb); end
    checks++; if (cap_ffs !== 1'b1) begin errors++; $display("FAIL first_fs: got %0b expected 1", cap_ffs); end
    checks++; if (cap_lx !== 10'd11 || cap_ly !== 10'd23) begin errors++; $display("FAIL last_coord: got x=%0d y=%0d expected 11/23", cap_lx, cap_ly); end
    checks++; if (cap_lrgb !== 24'h101FA5) begin errors++; $display("FAIL last_rgb: got %h expected 101fa5", cap_lrgb); end
    checks++; if (pix_err != 0 || show_cnt != HA * VA) begin errors++; $display("FAIL frame3_pixels: got bad=%0d shows=%0d expected 0/%0d", pix_err, show_cnt, HA * VA); end
  endtask

  task automatic test_long_line();
    clear_stats();
    model_on = 1'b0;
    drive_frame(8, HT + 1, HSW);
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL long_err_pulses: got %0d expected 1", err_pulses); end
    checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL long_err_cnt: got %0d expected 1", o_err_cnt); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL long_unlock: got %0b expected 0", o_locked); end
    clear_stats();
    drive_frame(-1, HT, HSW);
    checks++; if (o_locked !== 1'b0 || o_dbg_state !== 2'd1 || show_cnt != 0) begin errors++; $display("FAIL relock_measure: got locked=%0b state=%0d shows=%0d expected 0/1/0", o_locked, o_dbg_state, show_cnt); end
    clear_stats();
    model_on = 1'b1; model_locked = 1'b1;
    drive_frame(-1, HT, HSW);
    checks++; if (o_locked !== 1'b1 || pix_err != 0 || show_cnt != HA * VA) begin errors++; $display("FAIL relock_locked: got locked=%0b bad=%0d shows=%0d expected 1/0/%0d", o_locked, pix_err, show_cnt, HA * VA); end
  endtask

  task automatic test_short_hsync();
    clear_stats();
    model_on = 1'b0;
    drive_frame(6, HT, HSW - 1);
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL hsw_err_pulses: got %0d expected 1", err_pulses); end
    checks++; if (err_v != 6 || err_h != HSW - 1) begin errors++; $display("FAIL hsw_err_pos: got line=%0d col=%0d expected 6/%0d", err_v, err_h, HSW - 1); end
    checks++; if (o_dbg_state !== 2'd0 || o_locked !== 1'b0) begin errors++; $display("FAIL hsw_state: got state=%0d locked=%0b expected 0/0", o_dbg_state, o_locked); end
    checks++; if (o_err_cnt !== 8'd2) begin errors++; $display("FAIL hsw_err_cnt: got %0d expected 2", o_err_cnt); end
  endtask

  task automatic test_reset_mid_line();
    model_on = 1'b0;
    drive_frame(-1, HT, HSW);
    model_on = 1'b1; model_locked = 1'b1;
    for (int v = 0; v < 6; v++) drive_line(v, HT, HSW);
    drive_line(6, 16, HSW);
    checks++; if (o_show_en !== 1'b1 || o_x_cord !== 10'd1 || o_y_cord !== 10'd6) begin errors++; $display("FAIL pre_rst_pixel: got show=%0b x=%0d y=%0d expected 1/1/6", o_show_en, o_x_cord, o_y_cord); end
    model_on = 1'b0; model_locked = 1'b0;
    i_rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 24'h123456, 6, 16);
    checks++; if (o_locked !== 1'b0 || o_show_en !== 1'b0 || o_err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst: got locked=%0b show=%0b err_cnt=%0d expected 0/0/0", o_locked, o_show_en, o_err_cnt); end
    idle(2);
    i_rst = 1'b0;
    idle(4);
    clear_stats();
    model_on = 1'b1;
    drive_frame(-1, HT, HSW);
    checks++; if (o_locked !== 1'b0 || show_cnt != 0) begin errors++; $display("FAIL post_rst_measure: got locked=%0b shows=%0d expected 0/0", o_locked, show_cnt); end
    clear_stats();
    model_locked = 1'b1;
    drive_frame(-1, HT, HSW);
    checks++; if (o_locked !== 1'b1 || show_cnt != HA * VA || pix_err != 0 || o_err_cnt !== 8'd0) begin errors++; $display("FAIL post_rst_lock: got locked=%0b shows=%0d bad=%0d err_cnt=%0d expected 1/%0d/0/0", o_locked, show_cnt, pix_err, o_err_cnt, HA * VA); end
  endtask

  // A one-clock VS low pulse enters MEASURE and its rise fails the VS width check.
  task automatic test_err_saturate();
    model_on = 1'b0; model_locked = 1'b0;
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
    idle(3);
    clear_stats();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 1'b0, 24'd0, -1, -1);
      idle(2);
    end
    idle(2);
    checks++; if (o_err_cnt !== 8'd100) begin errors++; $display("FAIL sat_cnt_100: got %0d expected 100", o_err_cnt); end
    checks++; if (err_pulses != 100) begin errors++; $display("FAIL sat_pulses_100: got %0d expected 100", err_pulses); end
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 1'b0, 24'd0, -1, -1);
      idle(2);
    end
    idle(2);
    checks++; if (o_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_255: got %0d expected 255", o_err_cnt); end
    checks++; if (err_pulses != 300) begin errors++; $display("FAIL sat_pulses_300: got %0d expected 300", err_pulses); end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_pixel_coords();
    test_long_line();
    test_short_hsync();
    test_reset_mid_line();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
